// File: rtl/race_counter_bank.sv
// Multi-channel race-event counter bank: pipelined R-ary popcount tree per channel,
// saturating/wrapping accumulators with sticky overflow, threshold flags and a read(-and-clear) port.
module race_counter_bank #(
   parameter int unsigned NUM_CHANNELS   = 4,
   parameter int unsigned INPUT_WIDTH    = 256,
   parameter int unsigned COUNTER_WIDTH  = 32,
   parameter int unsigned REDUCTION_SIZE = 4,
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned SATURATE       = 1,
   parameter logic [COUNTER_WIDTH-1:0] THRESHOLD = {1'b1, {(COUNTER_WIDTH-1){1'b0}}},
   localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0]     race_occured_in,
   input  logic [NUM_CHANNELS-1:0]                 clear_in,
   input  logic                                    rd_req_valid_in,
   output logic                                    rd_req_ready_out,
   input  logic [CH_W-1:0]                         rd_req_channel_in,
   input  logic                                    rd_req_clear_in,
   output logic                                    rd_rsp_valid_out,
   input  logic                                    rd_rsp_ready_in,
   output logic [CH_W-1:0]                         rd_rsp_channel_out,
   output logic [COUNTER_WIDTH-1:0]                rd_rsp_count_out,
   output logic                                    rd_rsp_overflow_out,
   output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0]   race_count_out,
   output logic [NUM_CHANNELS-1:0]                 overflow_out,
   output logic [NUM_CHANNELS-1:0]                 threshold_out
);

   // min(R^k, INPUT_WIDTH): largest event count a level-k node can hold
   function automatic int unsigned span(input int unsigned k);
      int unsigned p = 1;
      for (int unsigned i = 0; i < k; i++) begin
         if (p < INPUT_WIDTH) p = p * REDUCTION_SIZE;
      end
      return (p < INPUT_WIDTH) ? p : INPUT_WIDTH;
   endfunction

   function automatic int unsigned num_levels();
      int unsigned p = 1;
      int unsigned l = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (p < INPUT_WIDTH) begin
            p = p * REDUCTION_SIZE;
            l = l + 1;
         end
      end
      return l;
   endfunction

   function automatic int unsigned nodes(input int unsigned k);
      int unsigned n = INPUT_WIDTH;
      for (int unsigned i = 0; i < k; i++) n = (n + REDUCTION_SIZE - 1) / REDUCTION_SIZE;
      return n;
   endfunction

   localparam int unsigned LEVELS = num_levels();
   localparam int unsigned STAGES = DEPTH - 1;
   localparam int unsigned INCR_W = $clog2(INPUT_WIDTH + 1);
   localparam int unsigned SUM_W  = ((COUNTER_WIDTH > INCR_W) ? COUNTER_WIDTH : INCR_W) + 1;

   // Spread the DEPTH-1 register stages evenly over the LEVELS+1 level boundaries
   function automatic int unsigned regs_at(input int unsigned b);
      return ((b + 1) * STAGES) / (LEVELS + 1) - (b * STAGES) / (LEVELS + 1);
   endfunction

   logic rd_accept;
   logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] rd_cnt_masked;
   logic [NUM_CHANNELS-1:0]               rd_ovf_masked;
   logic [COUNTER_WIDTH-1:0]              rd_sel_count;
   logic                                  rd_sel_ovf;
   logic                                  rsp_valid_q;
   logic [CH_W-1:0]                       rsp_channel_q;
   logic [COUNTER_WIDTH-1:0]              rsp_count_q;
   logic                                  rsp_ovf_q;

   for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned W  = $clog2(span(k) + 1);
      localparam int unsigned N  = nodes(k);
      localparam int unsigned NR = regs_at(k);
      localparam int unsigned FW = NUM_CHANNELS * N * W;
      logic [FW-1:0] sum_v;
      logic [FW-1:0] out_v;

      if (k == 0) begin : g_src
         assign sum_v = race_occured_in;
      end else begin : g_add
         localparam int unsigned PW = $clog2(span(k - 1) + 1);
         localparam int unsigned PN = nodes(k - 1);
         for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
            for (genvar i = 0; i < N; i++) begin : g_node
               localparam int unsigned NT = (PN - i * REDUCTION_SIZE < REDUCTION_SIZE) ?
                                            PN - i * REDUCTION_SIZE : REDUCTION_SIZE;
               logic [NT*PW-1:0] ops;
               logic [W-1:0]     acc;
               assign ops = g_lvl[k-1].out_v[(c*PN + i*REDUCTION_SIZE)*PW +: NT*PW];
               always_comb begin
                  acc = '0;
                  for (int unsigned j = 0; j < NT; j++) acc = acc + W'(PW'(ops >> (j * PW)));
               end
               assign sum_v[(c*N + i)*W +: W] = acc;
            end
         end
      end

      if (NR == 0) begin : g_comb
         assign out_v = sum_v;
      end else begin : g_pipe
         for (genvar s = 0; s < NR; s++) begin : g_stg
            logic [FW-1:0] q;
            if (s == 0) begin : g_first
               always_ff @(posedge clk) begin
                  if (rst) q <= '0;
                  else     q <= sum_v;
               end
            end else begin : g_next
               always_ff @(posedge clk) begin
                  if (rst) q <= '0;
                  else     q <= g_stg[s-1].q;
               end
            end
         end
         assign out_v = g_stg[NR-1].q;
      end
   end

   assign rd_req_ready_out = !rst && (!rsp_valid_q || rd_rsp_ready_in);
   assign rd_accept        = rd_req_valid_in && rd_req_ready_out;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [INCR_W-1:0]        incr;
      logic [COUNTER_WIDTH-1:0] count_q, count_d, base;
      logic [SUM_W-1:0]         sum;
      logic                     ovf_q, ovf_d, thr_q, thr_d;
      logic                     rd_match, rd_clr_hit;

      assign incr       = g_lvl[LEVELS].out_v[c*INCR_W +: INCR_W];
      assign rd_match   = (rd_req_channel_in == CH_W'(c));
      assign rd_clr_hit = rd_accept && rd_req_clear_in && rd_match;

      // Read-and-clear restarts accumulation from zero so this cycle's increment survives
      always_comb begin
         base    = rd_clr_hit ? '0 : count_q;
         sum     = SUM_W'(base) + SUM_W'(incr);
         count_d = sum[COUNTER_WIDTH-1:0];
         ovf_d   = ovf_q && !rd_clr_hit;
         if (|sum[SUM_W-1:COUNTER_WIDTH]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) count_d = '1;
         end
         if (clear_in[c]) begin
            count_d = '0;
            ovf_d   = 1'b0;
         end
         thr_d = !clear_in[c] && (count_d >= THRESHOLD);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            thr_q   <= 1'b0;
         end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            thr_q   <= thr_d;
         end
      end

      assign race_count_out[c*COUNTER_WIDTH +: COUNTER_WIDTH] = count_q;
      assign overflow_out[c]  = ovf_q;
      assign threshold_out[c] = thr_q;
      assign rd_cnt_masked[c*COUNTER_WIDTH +: COUNTER_WIDTH] = rd_match ? count_q : '0;
      assign rd_ovf_masked[c] = rd_match && ovf_q;
   end

   // Out-of-range channel indices match nothing and read back as zero
   always_comb begin
      rd_sel_count = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
         rd_sel_count = rd_sel_count | COUNTER_WIDTH'(rd_cnt_masked >> (c * COUNTER_WIDTH));
      rd_sel_ovf = |rd_ovf_masked;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q   <= 1'b0;
         rsp_channel_q <= '0;
         rsp_count_q   <= '0;
         rsp_ovf_q     <= 1'b0;
      end else if (rd_accept) begin
         rsp_valid_q   <= 1'b1;
         rsp_channel_q <= rd_req_channel_in;
         rsp_count_q   <= rd_sel_count;
         rsp_ovf_q     <= rd_sel_ovf;
      end else if (rd_rsp_ready_in) begin
         rsp_valid_q   <= 1'b0;
      end
   end

   assign rd_rsp_valid_out    = rsp_valid_q;
   assign rd_rsp_channel_out  = rsp_channel_q;
   assign rd_rsp_count_out    = rsp_count_q;
   assign rd_rsp_overflow_out = rsp_ovf_q;

endmodule

// File: tb/tb_race_counter_bank.sv
// Bench for race_counter_bank: delay-line/arithmetic reference model on a default-sized bank,
// plus two 8-bit instances for saturate, wrap, clear and threshold behaviour.
module tb_race_counter_bank;
   localparam int unsigned NC  = 4;
   localparam int unsigned IW  = 256;
   localparam int unsigned CW  = 32;
   localparam int unsigned DP  = 4;
   localparam int unsigned CHW = 2;
   localparam int unsigned SW  = 8;
   localparam longint unsigned CMAX = 64'hFFFF_FFFF;
   localparam longint unsigned THR  = 64'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [NC*IW-1:0]     race;
   logic [NC-1:0]        clr;
   logic                 rd_req_valid, rd_req_ready, rd_clr;
   logic [CHW-1:0]       rd_ch;
   logic                 rsp_valid, rsp_ready, rsp_ovf;
   logic [CHW-1:0]       rsp_ch;
   logic [CW-1:0]        rsp_cnt;
   logic [NC*CW-1:0]     counts;
   logic [NC-1:0]        ovf, thr;

   logic [NC*IW-1:0]     s_race;
   logic [NC-1:0]        s_clr;
   logic                 idle_lo = 1'b0;
   logic                 idle_hi = 1'b1;
   logic [CHW-1:0]       idle_ch = '0;
   logic                 s8_req_ready, s8_rsp_valid, s8_rsp_ovf;
   logic [CHW-1:0]       s8_rsp_ch;
   logic [SW-1:0]        s8_rsp_cnt;
   logic [NC*SW-1:0]     s8_counts;
   logic [NC-1:0]        s8_ovf, s8_thr;
   logic                 w8_req_ready, w8_rsp_valid, w8_rsp_ovf;
   logic [CHW-1:0]       w8_rsp_ch;
   logic [SW-1:0]        w8_rsp_cnt;
   logic [NC*SW-1:0]     w8_counts;
   logic [NC-1:0]        w8_ovf, w8_thr;

   race_counter_bank #(
      .NUM_CHANNELS(NC), .INPUT_WIDTH(IW), .COUNTER_WIDTH(CW), .REDUCTION_SIZE(4),
      .DEPTH(DP), .SATURATE(1)
   ) dut (
      .clk(clk), .rst(rst), .race_occured_in(race), .clear_in(clr),
      .rd_req_valid_in(rd_req_valid), .rd_req_ready_out(rd_req_ready),
      .rd_req_channel_in(rd_ch), .rd_req_clear_in(rd_clr),
      .rd_rsp_valid_out(rsp_valid), .rd_rsp_ready_in(rsp_ready),
      .rd_rsp_channel_out(rsp_ch), .rd_rsp_count_out(rsp_cnt), .rd_rsp_overflow_out(rsp_ovf),
      .race_count_out(counts), .overflow_out(ovf), .threshold_out(thr)
   );

   race_counter_bank #(
      .NUM_CHANNELS(NC), .INPUT_WIDTH(IW), .COUNTER_WIDTH(SW), .REDUCTION_SIZE(4),
      .DEPTH(DP), .SATURATE(1), .THRESHOLD(8'd128)
   ) dut_sat8 (
      .clk(clk), .rst(rst), .race_occured_in(s_race), .clear_in(s_clr),
      .rd_req_valid_in(idle_lo), .rd_req_ready_out(s8_req_ready),
      .rd_req_channel_in(idle_ch), .rd_req_clear_in(idle_lo),
      .rd_rsp_valid_out(s8_rsp_valid), .rd_rsp_ready_in(idle_hi),
      .rd_rsp_channel_out(s8_rsp_ch), .rd_rsp_count_out(s8_rsp_cnt), .rd_rsp_overflow_out(s8_rsp_ovf),
      .race_count_out(s8_counts), .overflow_out(s8_ovf), .threshold_out(s8_thr)
   );

   race_counter_bank #(
      .NUM_CHANNELS(NC), .INPUT_WIDTH(IW), .COUNTER_WIDTH(SW), .REDUCTION_SIZE(4),
      .DEPTH(DP), .SATURATE(0), .THRESHOLD(8'd128)
   ) dut_wrap8 (
      .clk(clk), .rst(rst), .race_occured_in(s_race), .clear_in(s_clr),
      .rd_req_valid_in(idle_lo), .rd_req_ready_out(w8_req_ready),
      .rd_req_channel_in(idle_ch), .rd_req_clear_in(idle_lo),
      .rd_rsp_valid_out(w8_rsp_valid), .rd_rsp_ready_in(idle_hi),
      .rd_rsp_channel_out(w8_rsp_ch), .rd_rsp_count_out(w8_rsp_cnt), .rd_rsp_overflow_out(w8_rsp_ovf),
      .race_count_out(w8_counts), .overflow_out(w8_ovf), .threshold_out(w8_thr)
   );

   int unsigned     n_tests = 0;
   int unsigned     n_fail  = 0;
   longint unsigned m_count [NC];
   bit              m_ovf   [NC];
   bit              m_thr   [NC];
   int unsigned     pend    [DP-1][NC];
   bit              m_rsp_valid;
   int unsigned     m_rsp_ch;
   longint unsigned m_rsp_cnt;
   bit              m_rsp_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: check ready, advance the reference model on the edge, compare registered outputs
   task automatic tick();
      int unsigned     pc [NC];
      bit              m_ready, acc, hit;
      longint unsigned base, sum;
      #1;
      m_ready = !rst && (!m_rsp_valid || rsp_ready);
      check("req_ready", 64'(rd_req_ready), 64'(m_ready));
      acc = rd_req_valid && m_ready;
      for (int c = 0; c < NC; c++) pc[c] = $countones(race[c*IW +: IW]);
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            m_count[c] = 0; m_ovf[c] = 0; m_thr[c] = 0;
            for (int s = 0; s < DP-1; s++) pend[s][c] = 0;
         end
         m_rsp_valid = 0; m_rsp_ch = 0; m_rsp_cnt = 0; m_rsp_ovf = 0;
      end else begin
         if (acc) begin
            m_rsp_valid = 1;
            m_rsp_ch    = rd_ch;
            m_rsp_cnt   = (rd_ch < NC) ? m_count[rd_ch] : 0;
            m_rsp_ovf   = (rd_ch < NC) ? m_ovf[rd_ch] : 0;
         end else if (rsp_ready) begin
            m_rsp_valid = 0;
         end
         for (int c = 0; c < NC; c++) begin
            hit = acc && rd_clr && (rd_ch == c);
            if (clr[c]) begin
               m_count[c] = 0; m_ovf[c] = 0; m_thr[c] = 0;
            end else begin
               base = hit ? 0 : m_count[c];
               sum  = base + pend[DP-2][c];
               if (sum > CMAX) begin
                  m_count[c] = CMAX;
                  m_ovf[c]   = 1;
               end else begin
                  m_count[c] = sum;
                  m_ovf[c]   = hit ? 0 : m_ovf[c];
               end
               m_thr[c] = (m_count[c] >= THR);
            end
            for (int s = DP-2; s > 0; s--) pend[s][c] = pend[s-1][c];
            pend[0][c] = pc[c];
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
         check($sformatf("count%0d", c), 64'(counts[c*CW +: CW]), m_count[c]);
         check($sformatf("ovf%0d", c), 64'(ovf[c]), 64'(m_ovf[c]));
         check($sformatf("thr%0d", c), 64'(thr[c]), 64'(m_thr[c]));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("rsp_ch", 64'(rsp_ch), 64'(m_rsp_ch));
      check("rsp_cnt", 64'(rsp_cnt), m_rsp_cnt);
      check("rsp_ovf", 64'(rsp_ovf), 64'(m_rsp_ovf));
   endtask

   initial begin
      logic [IW-1:0] v200;
      int unsigned   mode;
      logic [31:0]   word;

      rst = 1'b1; race = '0; clr = '0; rd_req_valid = 1'b0; rd_ch = '0; rd_clr = 1'b0;
      rsp_ready = 1'b1; s_race = '0; s_clr = '0;
      m_rsp_valid = 0; m_rsp_ch = 0; m_rsp_cnt = 0; m_rsp_ovf = 0;
      for (int c = 0; c < NC; c++) begin
         m_count[c] = 0; m_ovf[c] = 0; m_thr[c] = 0;
         for (int s = 0; s < DP-1; s++) pend[s][c] = 0;
      end

      repeat (50) tick();
      rst = 1'b0;
      tick();
      check("reset_ready", 64'(rd_req_ready), 64'd1);
      check("reset_count2", 64'(counts[2*CW +: CW]), 64'd0);

      // Single-bit walk on channel 2
      for (int j = 0; j < IW; j++) begin
         race = '0;
         race[2*IW + j] = 1'b1;
         tick();
      end
      race = '0;
      repeat (DP) tick();
      check("walk_ch2", 64'(counts[2*CW +: CW]), 64'd256);
      check("walk_ch0", 64'(counts[0 +: CW]), 64'd0);

      race = '1;
      tick();
      race = '0;
      repeat (DP - 1) tick();
      check("ones_early_ch2", 64'(counts[2*CW +: CW]), 64'd512);
      repeat (10) tick();
      check("ones_hold_ch2", 64'(counts[2*CW +: CW]), 64'd512);
      check("ones_hold_ch1", 64'(counts[1*CW +: CW]), 64'd256);

      // 8-bit saturate and wrap instances
      s_race = '1;
      repeat (2) tick();
      s_race = '0;
      repeat (DP) tick();
      check("sat8_count", 64'(s8_counts[0 +: SW]), 64'd255);
      check("sat8_ovf", 64'(s8_ovf[0]), 64'd1);
      check("sat8_thr", 64'(s8_thr[0]), 64'd1);
      check("wrap8_count", 64'(w8_counts[0 +: SW]), 64'd0);
      check("wrap8_ovf", 64'(w8_ovf[0]), 64'd1);
      check("wrap8_thr", 64'(w8_thr[0]), 64'd0);
      s_clr = '1;
      tick();
      s_clr = '0;
      check("sat8_clr_count", 64'(s8_counts[0 +: SW]), 64'd0);
      check("sat8_clr_ovf", 64'(s8_ovf[0]), 64'd0);
      check("wrap8_clr_ovf", 64'(w8_ovf[3]), 64'd0);
      v200 = '0;
      for (int i = 0; i < 200; i++) v200[i] = 1'b1;
      s_race[IW +: IW] = v200;
      tick();
      s_race = '0;
      repeat (DP) tick();
      check("thr8_count", 64'(s8_counts[SW +: SW]), 64'd200);
      check("thr8_flag", 64'(s8_thr[1]), 64'd1);
      check("thr8_wrap_flag", 64'(w8_thr[1]), 64'd1);
      check("thr8_ovf", 64'(s8_ovf[1]), 64'd0);

      // Back-to-back events on channel 0 with a read-and-clear mid-stream
      clr = 4'b0001;
      tick();
      clr = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         race[0] = 1'b1;
         rd_req_valid = (cyc == 10);
         rd_ch = '0;
         rd_clr = (cyc == 10);
         tick();
      end
      race = '0; rd_req_valid = 1'b0; rd_clr = 1'b0;
      repeat (DP) tick();
      check("b2b_total", 64'(rsp_cnt) + 64'(counts[0 +: CW]), 64'd20);

      // Back-pressure ordering
      rsp_ready = 1'b0;
      rd_req_valid = 1'b1; rd_ch = 2'd1;
      tick();
      rd_ch = 2'd3;
      repeat (3) tick();
      check("bp_hold_ch", 64'(rsp_ch), 64'd1);
      check("bp_req_ready", 64'(rd_req_ready), 64'd0);
      rsp_ready = 1'b1;
      tick();
      check("bp_second_ch", 64'(rsp_ch), 64'd3);
      check("bp_second_valid", 64'(rsp_valid), 64'd1);
      rd_req_valid = 1'b0;
      tick();

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int c = 0; c < NC; c++) begin
            mode = $urandom_range(0, 3);
            for (int w = 0; w < IW/32; w++) begin
               case (mode)
                  0:       word = '0;
                  1:       word = $urandom & $urandom & $urandom;
                  2:       word = $urandom;
                  default: word = ($urandom_range(0, 7) == 0) ? '1 : $urandom & $urandom;
               endcase
               race[(c*(IW/32) + w)*32 +: 32] = word;
            end
            clr[c] = ($urandom_range(0, 15) == 0);
         end
         rd_req_valid = $urandom_range(0, 1);
         rd_ch        = CHW'($urandom_range(0, NC-1));
         rd_clr       = $urandom_range(0, 1);
         rsp_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 1'b0; race = '0; clr = '0; rd_req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (DP + 2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
